// File: rtl/ss_scan_controller.sv
// Multiplexed seven-segment scanner for N common-anode digits with frame-synchronous
// shadow loading, PWM dimming, leading-zero suppression, per-digit blink and decimal points.
module ss_scan_controller #(
   parameter int N            = 4,
   parameter int SCAN_DIV     = 1024,
   parameter int BRIGHT_W     = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [N*4-1:0]      numbers,
   input  logic [N-1:0]        dp,
   input  logic [N-1:0]        blink_mask,
   input  logic                lz_en,
   input  logic [BRIGHT_W-1:0] brightness,
   output logic [N-1:0]        displays,
   output logic [6:0]          segments,
   output logic                dp_n,
   output logic                frame_done
);

   localparam int SLOT_W = $clog2(SCAN_DIV);
   localparam int DIG_W  = $clog2(N);
   localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(N - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h01;
         4'h1:    s = 7'h4F;
         4'h2:    s = 7'h12;
         4'h3:    s = 7'h06;
         4'h4:    s = 7'h4C;
         4'h5:    s = 7'h24;
         4'h6:    s = 7'h20;
         4'h7:    s = 7'h0F;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h04;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h60;
         4'hC:    s = 7'h31;
         4'hD:    s = 7'h42;
         4'hE:    s = 7'h30;
         default: s = 7'h38;
      endcase
      return s;
   endfunction

   // p0: scan position, blink phase and the shadow/active register pairs
   logic [SLOT_W-1:0] slot_cnt_p0;
   logic [DIG_W-1:0]  digit_p0;
   logic [BLK_W-1:0]  blink_cnt_p0;
   logic              blink_on_p0;
   logic              pending_p0;
   logic [N*4-1:0]    stage_num_p0, act_num_p0;
   logic [N-1:0]      stage_dp_p0, act_dp_p0;
   logic [N-1:0]      stage_blk_p0, act_blk_p0;

   // p1: registered pin drivers
   logic [N-1:0]      displays_p1;
   logic [6:0]        segments_p1;
   logic              dp_n_p1;
   logic              frame_done_p1;

   logic              slot_wrap, frame_wrap;
   logic [3:0]        nib;
   logic              dp_sel, blk_sel, supp_sel, lead, pwm_en, lit;
   logic [N-1:0]      sel_n, nxt_disp;
   logic [6:0]        nxt_seg;
   logic              nxt_dpn;

   always_comb begin
      slot_wrap  = (slot_cnt_p0 == SLOT_LAST);
      frame_wrap = slot_wrap && (digit_p0 == DIG_LAST);

      nib      = 4'h0;
      dp_sel   = 1'b0;
      blk_sel  = 1'b0;
      supp_sel = 1'b0;
      lead     = 1'b1;
      // lead stays set while every digit from the top down to i holds zero
      for (int i = N - 1; i >= 0; i--) begin
         if (act_num_p0[4*i +: 4] != 4'h0) lead = 1'b0;
         if (DIG_W'(i) == digit_p0) begin
            nib      = act_num_p0[4*i +: 4];
            dp_sel   = act_dp_p0[i];
            blk_sel  = act_blk_p0[i];
            supp_sel = lz_en && lead && (i != 0);
         end
      end

      // slot_cnt==0 stays dark at every brightness to hide digit-switch ghosting
      pwm_en = (slot_cnt_p0 != '0) && (slot_cnt_p0[BRIGHT_W-1:0] <= brightness);
      lit    = pwm_en && !(blk_sel && !blink_on_p0);
      sel_n  = ~({{(N-1){1'b0}}, 1'b1} << digit_p0);

      nxt_disp = '1;
      nxt_seg  = 7'h7F;
      nxt_dpn  = 1'b1;
      if (lit) begin
         if (!supp_sel) begin
            nxt_disp = sel_n;
            nxt_seg  = seg_decode(nib);
            nxt_dpn  = ~dp_sel;
         end else if (dp_sel) begin
            nxt_disp = sel_n;
            nxt_dpn  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_cnt_p0   <= '0;
         digit_p0      <= '0;
         blink_cnt_p0  <= '0;
         blink_on_p0   <= 1'b1;
         pending_p0    <= 1'b0;
         stage_num_p0  <= '0;
         stage_dp_p0   <= '0;
         stage_blk_p0  <= '0;
         act_num_p0    <= '0;
         act_dp_p0     <= '0;
         act_blk_p0    <= '0;
         displays_p1   <= '1;
         segments_p1   <= 7'h7F;
         dp_n_p1       <= 1'b1;
         frame_done_p1 <= 1'b0;
      end else begin
         slot_cnt_p0 <= slot_wrap ? '0 : slot_cnt_p0 + 1'b1;
         if (slot_wrap) digit_p0 <= frame_wrap ? '0 : digit_p0 + 1'b1;

         if (frame_wrap) begin
            if (blink_cnt_p0 == BLK_LAST) begin
               blink_cnt_p0 <= '0;
               blink_on_p0  <= ~blink_on_p0;
            end else begin
               blink_cnt_p0 <= blink_cnt_p0 + 1'b1;
            end
         end

         // a load on the wrap edge bypasses staging so the newest data wins
         if (load) begin
            if (frame_wrap) begin
               act_num_p0 <= numbers;
               act_dp_p0  <= dp;
               act_blk_p0 <= blink_mask;
               pending_p0 <= 1'b0;
            end else begin
               stage_num_p0 <= numbers;
               stage_dp_p0  <= dp;
               stage_blk_p0 <= blink_mask;
               pending_p0   <= 1'b1;
            end
         end else if (frame_wrap && pending_p0) begin
            act_num_p0 <= stage_num_p0;
            act_dp_p0  <= stage_dp_p0;
            act_blk_p0 <= stage_blk_p0;
            pending_p0 <= 1'b0;
         end

         displays_p1   <= nxt_disp;
         segments_p1   <= nxt_seg;
         dp_n_p1       <= nxt_dpn;
         frame_done_p1 <= frame_wrap;
      end
   end

   assign displays   = displays_p1;
   assign segments   = segments_p1;
   assign dp_n       = dp_n_p1;
   assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_ss_scan_controller.sv
// Scoreboard bench for ss_scan_controller: a frame/slot-arithmetic reference model
// predicts every output cycle; a negedge monitor pops and compares.
module tb_ss_scan_controller;
   localparam int N            = 4;
   localparam int SCAN_DIV     = 8;
   localparam int BRIGHT_W     = 2;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME        = N * SCAN_DIV;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                load = 1'b0;
   logic [N*4-1:0]      numbers = '0;
   logic [N-1:0]        dp = '0;
   logic [N-1:0]        blink_mask = '0;
   logic                lz_en = 1'b0;
   logic [BRIGHT_W-1:0] brightness = '1;
   logic [N-1:0]        displays;
   logic [6:0]          segments;
   logic                dp_n;
   logic                frame_done;

   always #5 clk = ~clk;

   ss_scan_controller #(
      .N(N), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .numbers(numbers), .dp(dp),
      .blink_mask(blink_mask), .lz_en(lz_en), .brightness(brightness),
      .displays(displays), .segments(segments), .dp_n(dp_n), .frame_done(frame_done)
   );

   typedef struct packed {
      logic [N-1:0] disp;
      logic [6:0]   seg;
      logic         dpn;
      logic         fd;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;

   int             mcyc = 0;
   logic [N*4-1:0] m_act_num = '0, m_stg_num = '0;
   logic [N-1:0]   m_act_dp = '0, m_stg_dp = '0, m_act_bm = '0, m_stg_bm = '0;
   bit             m_pend = 1'b0;

   task automatic check(input string name, input exp_t got, input exp_t exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s t=%0t: got disp=%b seg=%h dp_n=%b fd=%b, expected disp=%b seg=%h dp_n=%b fd=%b",
                  name, $time, got.disp, got.seg, got.dpn, got.fd,
                  exp.disp, exp.seg, exp.dpn, exp.fd);
      end
   endtask

   // Expected pins after the edge at cycle cyc (cycles counted from reset release).
   function automatic exp_t expect_at(input int cyc);
      exp_t e;
      int   slot, d, f, msnz;
      bit   pwm, on, supp;
      slot = cyc % SCAN_DIV;
      d    = (cyc / SCAN_DIV) % N;
      f    = cyc / FRAME;
      e.disp = '1;
      e.seg  = 7'h7F;
      e.dpn  = 1'b1;
      e.fd   = ((cyc % FRAME) == FRAME - 1);
      pwm  = (slot != 0) && ((slot % (1 << BRIGHT_W)) <= int'(brightness));
      on   = (((f / BLINK_FRAMES) % 2) == 0) || !m_act_bm[d];
      msnz = 0;
      for (int i = 0; i < N; i++)
         if (m_act_num[4*i +: 4] != 4'h0) msnz = i;
      supp = lz_en && (d > msnz);
      if (pwm && on) begin
         if (!supp) begin
            e.disp = ~(N'(1) << d);
            e.seg  = SEG_TAB[m_act_num[4*d +: 4]];
            e.dpn  = ~m_act_dp[d];
         end else if (m_act_dp[d]) begin
            e.disp = ~(N'(1) << d);
            e.dpn  = 1'b0;
         end
      end
      return e;
   endfunction

   // Reference model: predict this edge, then apply the frame-boundary data rules.
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         mcyc = 0;
         m_act_num = '0; m_act_dp = '0; m_act_bm = '0;
         m_stg_num = '0; m_stg_dp = '0; m_stg_bm = '0;
         m_pend = 1'b0;
      end else begin
         bit wrap;
         q.push_back(expect_at(mcyc));
         wrap = ((mcyc % FRAME) == FRAME - 1);
         if (load) begin
            if (wrap) begin
               m_act_num = numbers; m_act_dp = dp; m_act_bm = blink_mask; m_pend = 1'b0;
            end else begin
               m_stg_num = numbers; m_stg_dp = dp; m_stg_bm = blink_mask; m_pend = 1'b1;
            end
         end else if (wrap && m_pend) begin
            m_act_num = m_stg_num; m_act_dp = m_stg_dp; m_act_bm = m_stg_bm; m_pend = 1'b0;
         end
         mcyc++;
      end
   end

   // Monitor
   initial forever begin
      exp_t got, rst_exp;
      @(negedge clk);
      got     = {displays, segments, dp_n, frame_done};
      rst_exp = {{N{1'b1}}, 7'h7F, 1'b1, 1'b0};
      if (!rst) begin
         q.delete();
         check("reset_state", got, rst_exp);
      end else if (q.size() > 0) begin
         check("scan", got, q.pop_front());
      end
      compared++;
      if ($countones(~displays) > 1) begin
         mismatched++;
         $display("FAIL onehot t=%0t: displays=%b, required at most one low bit", $time, displays);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [N*4-1:0] v, input logic [N-1:0] d, input logic [N-1:0] bm);
      numbers    = v;
      dp         = d;
      blink_mask = bm;
      load       = 1'b1;
      step(1);
      load       = 1'b0;
   endtask

   initial begin
      exp_t got;
      step(2);
      #2 rst = 1'b1;
      step(3);

      do_load(16'h1234, 4'b0000, 4'b0000);
      step(2 * FRAME);

      brightness = 2'b00;
      step(FRAME);
      brightness = 2'b11;
      step(FRAME);

      lz_en = 1'b1;
      do_load(16'h0050, 4'b0000, 4'b0000);
      step(2 * FRAME);
      do_load(16'h0000, 4'b0000, 4'b0000);
      step(2 * FRAME);
      do_load(16'h0000, 4'b0100, 4'b0000);
      step(2 * FRAME);
      lz_en = 1'b0;

      while ((mcyc % FRAME) != 3) step(1);
      do_load(16'hAAAA, 4'b0000, 4'b0000);
      step(10);
      do_load(16'hBBBB, 4'b0000, 4'b0000);
      step(2 * FRAME);

      while ((mcyc % FRAME) != FRAME - 1) step(1);
      do_load(16'hFFFF, 4'b0000, 4'b0000);
      step(FRAME);

      do_load(16'h1234, 4'b0010, 4'b0001);
      step(5 * FRAME);

      for (int c = 0; c < 1500; c++) begin
         if (c % 50 == 0) begin
            lz_en      = 1'($urandom_range(0, 1));
            brightness = BRIGHT_W'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 19) == 0) begin
            for (int i = 0; i < N; i++)
               numbers[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            dp         = N'($urandom);
            blink_mask = N'($urandom);
            load       = 1'b1;
         end else begin
            load = 1'b0;
         end
         step(1);
      end
      load = 1'b0;
      brightness = 2'b11;
      lz_en = 1'b0;
      step(2 * FRAME);

      while ((mcyc % FRAME) != 2 * SCAN_DIV + 3) step(1);
      do_load(16'h9999, 4'b1111, 4'b0000);
      step(2);
      #1 rst = 1'b0;
      #1;
      got = {displays, segments, dp_n, frame_done};
      check("async_reset", got, {{N{1'b1}}, 7'h7F, 1'b1, 1'b0});
      step(3);
      #2 rst = 1'b1;
      step(3 * FRAME);

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "timeout");
   end

endmodule
